filter_accel_mul_arb: RTL and testbench

FILTER_ACCEL_MUL_ARB -- requirements
Module: filter_accel_mul_arb

---
 rtl/filter_accel_mul_arb_pkg.sv | 22 ++
 rtl/filter_accel_mul_arb_dsp.sv | 70 +++++++
 rtl/filter_accel_mul_arb.sv | 123 ++++++++++++
 tb/tb_filter_accel_mul_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_accel_mul_arb_pkg.sv
// Shared constants and types for the round-robin shared-multiplier block.
// FILTER_ACCEL_MUL_ARB_PIPE_REG_EN adds a multiplier output register (latency 2 instead of 1).
`timescale 1ns/1ps
package filter_accel_mul_arb_pkg;

  localparam int A_WIDTH_DEF = 7;
  localparam int B_WIDTH_DEF = 11;
  localparam int P_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF;

`ifdef FILTER_ACCEL_MUL_ARB_PIPE_REG_EN
  localparam int MUL_LATENCY = 2;
`else
  localparam int MUL_LATENCY = 1;
`endif

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_BUSY = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_t;

endpackage

// File: rtl/filter_accel_mul_arb_dsp.sv
// Registered unsigned multiplier with requester-tag/valid pipeline.
// Depth is MUL_LATENCY, i.e. 2 when FILTER_ACCEL_MUL_ARB_PIPE_REG_EN is defined, else 1.
`timescale 1ns/1ps
module filter_accel_mul_arb_dsp
  import filter_accel_mul_arb_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int TAG_W   = 2
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               i_valid,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [B_WIDTH-1:0] i_b,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [P_WIDTH-1:0] o_p
);

  logic               r_v1;
  logic [TAG_W-1:0]   r_tag1;
  logic [P_WIDTH-1:0] r_p1;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_v1   <= 1'b0;
      r_tag1 <= '0;
      r_p1   <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_tag1 <= i_tag;
        r_p1   <= P_WIDTH'(i_a) * P_WIDTH'(i_b);
      end
    end
  end

  if (MUL_LATENCY > 1) begin : g_out_reg
    logic               r_v2;
    logic [TAG_W-1:0]   r_tag2;
    logic [P_WIDTH-1:0] r_p2;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_v2   <= 1'b0;
        r_tag2 <= '0;
        r_p2   <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_tag2 <= r_tag1;
          r_p2   <= r_p1;
        end
      end
    end

    assign o_valid = r_v2;
    assign o_tag   = r_tag2;
    assign o_p     = r_p2;
  end else begin : g_no_out_reg
    assign o_valid = r_v1;
    assign o_tag   = r_tag1;
    assign o_p     = r_p1;
  end

endmodule

// File: rtl/filter_accel_mul_arb.sv
// N_REQ requesters share one multiplier through a round-robin arbiter with per-requester result slots.
// Build option FILTER_ACCEL_MUL_ARB_PIPE_REG_EN (see package) selects multiplier latency.
`timescale 1ns/1ps
module filter_accel_mul_arb
  import filter_accel_mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*A_WIDTH-1:0] req_a,
  input  logic [N_REQ*B_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [N_REQ*P_WIDTH-1:0] rsp_p,
  output logic                     busy,
  output logic [15:0]              op_count
);

  localparam int TAG_W = $clog2(N_REQ);

  slot_state_t              r_state [N_REQ];
  logic [TAG_W-1:0]         r_ptr;
  logic [N_REQ*P_WIDTH-1:0] r_rsp_p;
  logic [15:0]              r_op_count;

  logic [N_REQ-1:0]   w_elig;
  logic               w_grant_any;
  logic [TAG_W-1:0]   w_grant_idx;
  logic [A_WIDTH-1:0] w_op_a;
  logic [B_WIDTH-1:0] w_op_b;
  logic               w_dsp_valid;
  logic [TAG_W-1:0]   w_dsp_tag;
  logic [P_WIDTH-1:0] w_dsp_p;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_elig    = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i]    = req_valid[i] && (r_state[i] == SLOT_IDLE);
      rsp_valid[i] = (r_state[i] == SLOT_DONE);
      if (r_state[i] != SLOT_IDLE) busy = 1'b1;
    end
  end

  // Scan from the pointer; a slot in DONE is never eligible, so a freed slot waits one cycle.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_grant_any && w_elig[idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant_any) req_ready[w_grant_idx] = 1'b1;
  end

  assign w_op_a = req_a[w_grant_idx*A_WIDTH +: A_WIDTH];
  assign w_op_b = req_b[w_grant_idx*B_WIDTH +: B_WIDTH];

  filter_accel_mul_arb_dsp #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH),
    .TAG_W   (TAG_W)
  ) u_dsp (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .i_valid  (w_grant_any),
    .i_tag    (w_grant_idx),
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .o_valid  (w_dsp_valid),
    .o_tag    (w_dsp_tag),
    .o_p      (w_dsp_p)
  );

  // NOTE: the slot array is control state, not a RAM, so every entry is reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < N_REQ; i++) r_state[i] <= SLOT_IDLE;
      r_ptr      <= '0;
      r_rsp_p    <= '0;
      r_op_count <= '0;
    end else begin
      if (w_grant_any) begin
        r_ptr      <= (w_grant_idx == TAG_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        r_op_count <= r_op_count + 16'd1;
      end
      for (int i = 0; i < N_REQ; i++) begin
        case (r_state[i])
          SLOT_IDLE: if (w_grant_any && w_grant_idx == TAG_W'(i)) r_state[i] <= SLOT_BUSY;
          SLOT_BUSY: if (w_dsp_valid && w_dsp_tag == TAG_W'(i)) begin
            r_state[i]                     <= SLOT_DONE;
            r_rsp_p[i*P_WIDTH +: P_WIDTH]  <= w_dsp_p;
          end
          SLOT_DONE: if (rsp_ready[i]) r_state[i] <= SLOT_IDLE;
          default:   r_state[i] <= SLOT_IDLE;
        endcase
      end
    end
  end

  assign rsp_p    = r_rsp_p;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_filter_accel_mul_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_filter_accel_mul_arb;
  import filter_accel_mul_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = A_WIDTH_DEF;
  localparam int BW = B_WIDTH_DEF;
  localparam int PW = P_WIDTH_DEF;
  localparam int L  = MUL_LATENCY;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [N*PW-1:0]   rsp_p;
  logic              busy;
  logic [15:0]       op_count;

  always #5 ap_clk = ~ap_clk;

  filter_accel_mul_arb #(
    .N_REQ   (N),
    .A_WIDTH (AW),
    .B_WIDTH (BW),
    .P_WIDTH (PW)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .op_count  (op_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a requester owns its slot from accept until its response handshake;
  // the response is visible once L clock edges have passed since the accept.
  bit m_owned [N];
  int m_due   [N];
  int m_exp   [N];
  int m_ptr;
  int m_cnt;
  int last_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i] && !m_owned[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_owned[i] = 1'b0;
      m_due[i]   = 0;
      m_exp[i]   = 0;
    end
    m_ptr = 0;
    m_cnt = 0;
    last_grant = -1;
  endtask

  task automatic check_outputs();
    int w;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic eb;
    w  = winner();
    er = '0;
    ev = '0;
    eb = 1'b0;
    if (w >= 0) er[w] = 1'b1;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_owned[i] && (m_due[i] == 0);
      if (m_owned[i]) eb = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(er));
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    check("busy", 64'(busy), 64'(eb));
    check("op_count", 64'(op_count), 64'(m_cnt));
    for (int i = 0; i < N; i++)
      if (ev[i]) check("rsp_p", 64'(rsp_p[i*PW +: PW]), 64'(m_exp[i]));
  endtask

  task automatic model_edge();
    int w;
    w = winner();
    last_grant = w;
    for (int i = 0; i < N; i++) begin
      if (m_owned[i] && m_due[i] == 0 && rsp_ready[i]) m_owned[i] = 1'b0;
      else if (m_owned[i] && m_due[i] > 0) m_due[i]--;
    end
    if (w >= 0) begin
      m_owned[w] = 1'b1;
      m_due[w]   = L;
      m_exp[w]   = int'(req_a[w*AW +: AW]) * int'(req_b[w*BW +: BW]);
      m_ptr      = (w + 1) % N;
      m_cnt      = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
    check_outputs();
    model_edge();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = AW'($urandom);
      req_b[i*BW +: BW] = BW'($urandom);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_op_count"}, 64'(op_count), 64'd0);
    for (int i = 0; i < N; i++) check({tag, "_rsp_p"}, 64'(rsp_p[i*PW +: PW]), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    req_valid = '0;
    ap_rst_n  = 1'b0;
    #1;
    check_reset(tag);
    model_reset();
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int g [5];
    int guard;

    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    check_reset("reset");
    ap_rst_n = 1'b1;
    tick();

    // Single request at full-scale operands
    req_a[0 +: AW] = AW'(127);
    req_b[0 +: BW] = BW'(2047);
    req_valid      = 4'b0001;
    #1;
    check("single_ready", 64'(req_ready[0]), 64'd1);
    tick();
    req_valid = '0;
    lat = 0;
    while (rsp_valid[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("single_latency", 64'(lat), 64'(L));
    check("single_p", 64'(rsp_p[0 +: PW]), 64'd259969);
    check("single_count", 64'(op_count), 64'd1);
    rsp_ready = 4'b0001;
    tick();

    // All requesters valid every cycle, responses always accepted
    do_reset("rst_rr");
    rsp_ready = '1;
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      tick();
      g[c] = last_grant;
    end
    for (int c = 0; c < 5; c++) check("rr_order", 64'(g[c]), 64'(c % N));
    for (int c = 0; c < 16; c++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (L + 3) tick();

    // Backpressure on requester 1
    req_valid       = 4'b0010;
    req_a[AW +: AW] = AW'(3);
    req_b[BW +: BW] = BW'(5);
    rsp_ready       = 4'b1101;
    #1;
    check("bp_ready", 64'(req_ready[1]), 64'd1);
    tick();
    repeat (L) tick();
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 64'(rsp_valid[1]), 64'd1);
      check("bp_p", 64'(rsp_p[PW +: PW]), 64'd15);
      check("bp_no_ready", 64'(req_ready[1]), 64'd0);
      tick();
    end
    rsp_ready[1] = 1'b1;
    #1;
    check("bp_hs_no_ready", 64'(req_ready[1]), 64'd0);
    tick();
    check("bp_regrant", 64'(req_ready[1]), 64'd1);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (L + 3) tick();

    // Reset while requester 2 is in flight
    rand_ops();
    req_valid = 4'b0100;
    rsp_ready = '0;
    tick();
    req_valid = '0;
    ap_rst_n  = 1'b0;
    #1;
    check_reset("mid_reset");
    model_reset();
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    for (int c = 0; c < L + 4; c++) begin
      check("no_stale_rsp", 64'(rsp_valid[2]), 64'd0);
      tick();
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      tick();
    end

    // Drive op_count through its wrap to 0
    req_valid = '1;
    rsp_ready = '1;
    guard = 0;
    do begin
      rand_ops();
      tick();
      guard++;
    end while (m_cnt != 0 && guard < 70000);
    check("wrap_in_budget", 64'(guard < 70000), 64'd1);
    req_valid = '0;
    check("wrap_count", 64'(op_count), 64'd0);
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("busy_fall", 64'(busy), 64'd0);
    check("wrap_count_idle", 64'(op_count), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
